branch_ctrl: RTL and testbench
==============================

// Module: branch_ctrl
// PURPOSE
//  Control-flow source for the fetch unit: decodes the fetched instruction and drives IF's Branch_abs,
//  FLAG_IN, Target and Halt inputs. Holds the FLAG register, a target LUT, a run/halt FSM and a watchdog.
//  Sits between instruction memory (Instr, combinational at current PC) and IF; outputs for the current
//  Instr are combinational from Instr plus registered state, so IF acts on them at the next posedge.
// PARAMETERS
//  LUT_AW    5        LUT address width; LUT depth = 2**LUT_AW entries of 16 bits
//  WDOG_MAX  16'hFFFF run-cycle limit before forced halt; 0 disables watchdog
// PORTS
//  CLK           in   1   clock; all state changes on posedge only
//  Init          in   1   reset, synchronous active-high; priority over everything
//  Instr         in   9   fetched instruction; [8:5] opcode, [4:0] LUT index
//  Cmp_Result    in   1   ALU compare result, sampled on OP_CMP
//  Lut_We        in   1   target LUT write enable
//  Lut_Addr      in   LUT_AW  LUT write address
//  Lut_Data      in   16  LUT write data
//  Branch_abs    out  1   to IF: branch-class instruction present
//  FLAG_OUT      out  1   to IF FLAG_IN: branch taken qualifier
//  Target        out  16  to IF: absolute branch target = LUT[Instr[4:0]]
//  Halt          out  1   to IF: freeze PC
//  Done          out  1   registered; 1 while HALTED
//  Timeout       out  1   registered; 1 if halt was forced by watchdog
//  Cycle_Count   out  16  RUN cycles since Init, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset (Init=1 at posedge): state<=RUN, flag_q<=0, Done<=0, Timeout<=0, Cycle_Count<=0. LUT not cleared.
//  During Init cycle, outputs decode normally; IF's own Init dominates PC.
//  FSM RUN: OP_CMP(4'hC): flag_q<=Cmp_Result at posedge; control outputs 0.
//    OP_BR(4'hD): Branch_abs=1, FLAG_OUT=flag_q, Target=LUT[idx]. OP_JMP(4'hE): Branch_abs=1, FLAG_OUT=1.
//    OP_HALT(4'hF): Halt=1 same cycle; posedge -> HALTED, Done<=1. Other opcodes: all control outputs 0.
//  FSM HALTED: Halt=1, Branch_abs=0, FLAG_OUT=0; flag_q, Cycle_Count frozen; exit only via Init.
//  Target is always LUT[Instr[4:0]] (don't-care unless Branch_abs); LUT read is combinational.
//  LUT write on posedge when Lut_We, any state; same-cycle read of written address returns old value.
//  BR after CMP sees the CMP result (flag_q updated at the intervening edge).
//  Cycle_Count increments each RUN posedge without Init; saturates, never wraps.
//  Watchdog (WDOG_MAX!=0): in RUN when Cycle_Count==WDOG_MAX, Halt=1 combinationally and branch outputs
//    forced 0; posedge -> HALTED, Done<=1, Timeout<=1. If OP_HALT coincides, Timeout<=1 still (watchdog wins).
//  Init mid-HALT or mid-program: restart as reset; no pending state survives.
// CONFIGURATION
//  BRANCH_STATS_EN defined: extra port Taken_Count out 16 = count of RUN posedges with Branch_abs&FLAG_OUT,
//    saturating at 16'hFFFF, cleared by Init. Undefined: port and counter absent; no other change.
// STRUCTURE
//  Package branch_pkg: opcode typedef/constants OP_CMP/OP_BR/OP_JMP/OP_HALT, state_t {RUN, HALTED},
//    INSTR_W=9, OPC_MSB/LSB field constants.
//  Sub-module branch_lut: 2**LUT_AW x 16 array, sync write, async read.
// TESTING
//  LUT[3]=16'h0040; Instr=CMP with Cmp_Result=1, then BR idx3 -> Branch_abs=1, FLAG_OUT=1, Target=16'h0040.
//  CMP with Cmp_Result=0, then BR idx3 -> Branch_abs=1, FLAG_OUT=0 (IF falls through to PC+1).
//  JMP idx7 with flag_q=0, LUT[7]=16'h0123 -> FLAG_OUT=1, Target=16'h0123.
//  HALT -> Halt=1 same cycle; next cycle Done=1, Halt stays 1 for 10 cycles; Init -> Done=0, flag_q=0.
//  WDOG_MAX=16'd20, program looping via JMP -> Halt=1 at Cycle_Count=20, Done=1, Timeout=1, count frozen.
//  Lut_We to addr 3 with data 16'hBEEF while BR idx3 -> Target old value that cycle, 16'hBEEF next cycle.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch controller: instruction field layout,
// control opcodes and the run/halt state encoding.
package branch_pkg;

  localparam int INSTR_W = 9;
  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 5;
  localparam int IDX_MSB = 4;
  localparam int IDX_LSB = 0;

  typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;

  localparam opcode_t OP_CMP  = 4'hC;
  localparam opcode_t OP_BR   = 4'hD;
  localparam opcode_t OP_JMP  = 4'hE;
  localparam opcode_t OP_HALT = 4'hF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  function automatic opcode_t get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch target table: synchronous write, combinational read. Contents are not
// reset; a read of the address being written this cycle returns the old word.
module branch_lut #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/branch_ctrl.sv
// Control-flow source for the fetch unit: FLAG register, target LUT, run/halt FSM
// and run-cycle watchdog. Defining BRANCH_STATS_EN adds the Taken_Count port.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int          LUT_AW   = 5,
  parameter logic [15:0] WDOG_MAX = 16'hFFFF
) (
  input  logic               CLK,
  input  logic               Init,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               Cmp_Result,
  input  logic               Lut_We,
  input  logic [LUT_AW-1:0]  Lut_Addr,
  input  logic [15:0]        Lut_Data,
  output logic               Branch_abs,
  output logic               FLAG_OUT,
  output logic [15:0]        Target,
  output logic               Halt,
  output logic               Done,
  output logic               Timeout,
`ifdef BRANCH_STATS_EN
  output logic [15:0]        Taken_Count,
`endif
  output logic [15:0]        Cycle_Count
);

  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  state_t      state_q;
  logic        flag_q;
  logic        done_q;
  logic        timeout_q;
  logic [15:0] cnt_q;
  opcode_t     opcode;
  logic        wdog_hit;
  logic        br_d;
  logic        flag_d;
  logic        halt_d;

  assign opcode = get_opcode(Instr);

  branch_lut #(
    .AW (LUT_AW),
    .DW (16)
  ) u_lut (
    .clk     (CLK),
    .we_i    (Lut_We),
    .waddr_i (Lut_Addr),
    .wdata_i (Lut_Data),
    .raddr_i (Instr[LUT_AW-1:0]),
    .rdata_o (Target)
  );

  // A zero limit disables the watchdog entirely.
  assign wdog_hit = (WDOG_MAX != 16'd0) && (state_q == RUN) && (cnt_q == WDOG_MAX);

  always_comb begin
    br_d   = 1'b0;
    flag_d = 1'b0;
    halt_d = 1'b0;
    if (state_q == HALTED || wdog_hit) begin
      halt_d = 1'b1;
    end else begin
      case (opcode)
        OP_BR: begin
          br_d   = 1'b1;
          flag_d = flag_q;
        end
        OP_JMP: begin
          br_d   = 1'b1;
          flag_d = 1'b1;
        end
        OP_HALT: halt_d = 1'b1;
        default: ;
      endcase
    end
  end

  assign Branch_abs  = br_d;
  assign FLAG_OUT    = flag_d;
  assign Halt        = halt_d;
  assign Done        = done_q;
  assign Timeout     = timeout_q;
  assign Cycle_Count = cnt_q;

  always_ff @(posedge CLK) begin
    if (Init) begin
      state_q   <= RUN;
      flag_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (opcode == OP_CMP) begin
            flag_q <= Cmp_Result;
          end
          // The count stops at the watchdog limit so it reads back the limit after a forced halt.
          if (wdog_hit) begin
            state_q   <= HALTED;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            if (cnt_q != CNT_SAT) begin
              cnt_q <= cnt_q + 16'd1;
            end
            if (opcode == OP_HALT) begin
              state_q <= HALTED;
              done_q  <= 1'b1;
            end
          end
        end
        HALTED: ;
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_q;

  always_ff @(posedge CLK) begin
    if (Init) begin
      taken_q <= 16'd0;
    end else if (br_d && flag_d && taken_q != CNT_SAT) begin
      taken_q <= taken_q + 16'd1;
    end
  end

  assign Taken_Count = taken_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a behavioural model.
module tb_branch_ctrl;

  localparam logic [15:0] WD = 16'd20;

  logic        CLK = 1'b0;
  logic        Init = 1'b1;
  logic [8:0]  Instr = 9'd0;
  logic        Cmp_Result = 1'b0;
  logic        Lut_We = 1'b0;
  logic [4:0]  Lut_Addr = 5'd0;
  logic [15:0] Lut_Data = 16'd0;
  logic        Branch_abs, FLAG_OUT, Halt, Done, Timeout;
  logic [15:0] Target, Cycle_Count;
`ifdef BRANCH_STATS_EN
  logic [15:0] Taken_Count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  branch_ctrl #(.LUT_AW(5), .WDOG_MAX(WD)) dut (
    .CLK         (CLK),
    .Init        (Init),
    .Instr       (Instr),
    .Cmp_Result  (Cmp_Result),
    .Lut_We      (Lut_We),
    .Lut_Addr    (Lut_Addr),
    .Lut_Data    (Lut_Data),
    .Branch_abs  (Branch_abs),
    .FLAG_OUT    (FLAG_OUT),
    .Target      (Target),
    .Halt        (Halt),
    .Done        (Done),
    .Timeout     (Timeout),
`ifdef BRANCH_STATS_EN
    .Taken_Count (Taken_Count),
`endif
    .Cycle_Count (Cycle_Count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [8:0] ins(input logic [3:0] op, input logic [4:0] idx);
    return {op, idx};
  endfunction

  // One cycle: apply inputs just after the posedge, return at the following negedge.
  task automatic cyc(input logic init, input logic [8:0] instr, input logic cmp,
                     input logic we, input logic [4:0] a, input logic [15:0] d);
    @(posedge CLK);
    #1;
    Init = init; Instr = instr; Cmp_Result = cmp;
    Lut_We = we; Lut_Addr = a; Lut_Data = d;
    @(negedge CLK);
  endtask

  // Behavioural model: program state as plain variables, LUT as an array.
  bit          m_started = 0;
  bit          m_halted = 0, m_flag = 0, m_timeout = 0;
  int          m_count = 0, m_taken = 0;
  logic [15:0] m_lut [32];
  bit          m_valid [32];

  initial begin
    for (int i = 0; i < 32; i++) m_valid[i] = 0;
  end

  always @(negedge CLK) begin
    logic [3:0] op;
    bit wd, e_halt, e_br, e_flag;
    op     = Instr[8:5];
    wd     = !m_halted && (m_count == int'(WD));
    e_halt = m_halted || wd || (op == 4'hF);
    e_br   = !m_halted && !wd && (op == 4'hD || op == 4'hE);
    e_flag = e_br && (op == 4'hE || m_flag);
    if (m_started) begin
      chk("m_branch_abs", {31'd0, Branch_abs}, {31'd0, e_br});
      chk("m_flag_out", {31'd0, FLAG_OUT}, {31'd0, e_flag});
      chk("m_halt", {31'd0, Halt}, {31'd0, e_halt});
      chk("m_done", {31'd0, Done}, {31'd0, m_halted});
      chk("m_timeout", {31'd0, Timeout}, {31'd0, m_timeout});
      chk("m_cycle_count", {16'd0, Cycle_Count}, m_count);
      if (m_valid[Instr[4:0]]) chk("m_target", {16'd0, Target}, {16'd0, m_lut[Instr[4:0]]});
`ifdef BRANCH_STATS_EN
      chk("m_taken_count", {16'd0, Taken_Count}, m_taken);
`endif
    end
    if (Init) begin
      m_started = 1; m_halted = 0; m_flag = 0; m_timeout = 0; m_count = 0; m_taken = 0;
    end else if (m_started && !m_halted) begin
      if (op == 4'hC) m_flag = Cmp_Result;
      if (e_br && e_flag && m_taken < 65535) m_taken++;
      if (wd) begin
        m_halted = 1; m_timeout = 1;
      end else begin
        if (m_count < 65535) m_count++;
        if (op == 4'hF) m_halted = 1;
      end
    end
    if (Lut_We) begin
      m_lut[Lut_Addr] = Lut_Data;
      m_valid[Lut_Addr] = 1;
    end
  end

  initial begin
    // Preload the whole LUT while held in Init.
    for (int i = 0; i < 32; i++) begin
      logic [15:0] d;
      d = (i == 3) ? 16'h0040 : (i == 7) ? 16'h0123 : 16'($urandom);
      cyc(1, 9'd0, 0, 1, 5'(i), d);
    end

    cyc(0, ins(4'hC, 0), 1, 0, 0, 0);
    chk("cmp_ctrl_zero", {29'd0, Branch_abs, FLAG_OUT, Halt}, 0);
    chk("cnt_after_init", {16'd0, Cycle_Count}, 0);
    cyc(0, ins(4'hD, 3), 0, 0, 0, 0);
    chk("br_taken", {30'd0, Branch_abs, FLAG_OUT}, 32'b11);
    chk("br_target", {16'd0, Target}, 32'h0040);
    cyc(0, ins(4'hC, 0), 0, 0, 0, 0);
    cyc(0, ins(4'hD, 3), 0, 0, 0, 0);
    chk("br_not_taken", {30'd0, Branch_abs, FLAG_OUT}, 32'b10);
    cyc(0, ins(4'hE, 7), 0, 0, 0, 0);
    chk("jmp_flag", {30'd0, Branch_abs, FLAG_OUT}, 32'b11);
    chk("jmp_target", {16'd0, Target}, 32'h0123);
    cyc(0, ins(4'hC, 0), 1, 0, 0, 0);
    cyc(0, ins(4'hF, 0), 0, 0, 0, 0);
    chk("halt_same_cycle", {30'd0, Halt, Done}, 32'b10);
    chk("cnt_at_halt", {16'd0, Cycle_Count}, 6);
    for (int i = 0; i < 10; i++) begin
      cyc(0, ins(4'hE, 7), 0, 0, 0, 0);
      chk("halted_state", {28'd0, Halt, Done, Branch_abs, FLAG_OUT}, 32'b1100);
      chk("halted_cnt_frozen", {16'd0, Cycle_Count}, 7);
    end

    // Restart, then loop until the watchdog fires on a coincident HALT.
    cyc(1, ins(4'hD, 3), 0, 0, 0, 0);
    chk("init_in_halt_decodes", {31'd0, Halt}, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(0, (i == 0) ? ins(4'hD, 3) : ins(4'hE, 7), 0, 0, 0, 0);
      if (i == 0) begin
        chk("reinit_done_clear", {30'd0, Done, Halt}, 0);
        chk("reinit_flag_clear", {30'd0, Branch_abs, FLAG_OUT}, 32'b10);
      end
    end
    cyc(0, ins(4'hF, 0), 0, 0, 0, 0);
    chk("wdog_halt", {29'd0, Halt, Branch_abs, Done}, 32'b100);
    chk("wdog_cnt", {16'd0, Cycle_Count}, 20);
    for (int i = 0; i < 3; i++) begin
      cyc(0, ins(4'hE, 7), 0, 0, 0, 0);
      chk("wdog_timeout", {29'd0, Done, Timeout, Halt}, 32'b111);
      chk("wdog_cnt_frozen", {16'd0, Cycle_Count}, 20);
    end

    // LUT write during a read of the same entry.
    cyc(1, ins(4'hD, 3), 0, 0, 0, 0);
    cyc(0, ins(4'hD, 3), 0, 1, 3, 16'hBEEF);
    chk("lut_old_value", {16'd0, Target}, 32'h0040);
    cyc(0, ins(4'hD, 3), 0, 0, 0, 0);
    chk("lut_new_value", {16'd0, Target}, 32'hBEEF);

    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [3:0] op;
      r = $urandom_range(0, 19);
      op = (r < 3) ? 4'($urandom_range(0, 11)) : (r < 8) ? 4'hC :
           (r < 14) ? 4'hD : (r < 19) ? 4'hE : 4'hF;
      cyc(($urandom_range(0, 39) == 0), ins(op, 5'($urandom)), 1'($urandom),
          ($urandom_range(0, 3) == 0), 5'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
